// File: rtl/dnn_l1_mac.sv
// First hidden DNN layer: buffers one context window of NIN samples, then
// evaluates NOUT neurons one at a time as ReLU((sum(x*w) + b) >>> FRAC), saturated.
module dnn_l1_mac #(
  parameter int IBIT   = 13,
  parameter int WBIT   = 13,
  parameter int BBIT   = 16,
  parameter int ACCBIT = 34,
  parameter int FRAC   = 12,
  parameter int OBIT   = 13,
  parameter int NIN    = 60,
  parameter int NOUT   = 32,
  parameter int WABIT  = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dv_i,
  input  logic signed [IBIT-1:0]   vec_i,
  output logic        [WABIT-1:0]  w_addr,
  input  logic signed [WBIT-1:0]   w_data,
  output logic        [7:0]        b_addr,
  input  logic signed [BBIT-1:0]   b_data,
  output logic                     dv_o,
  output logic signed [OBIT-1:0]   vec_o,
  output logic        [7:0]        index_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     ovr_o
);

  localparam int P   = NIN + 2;
  localparam int CW  = $clog2(NIN);
  localparam int PCW = $clog2(P);
  localparam int PW  = IBIT + WBIT;

  localparam logic [CW-1:0]    CNT_LAST = CW'(NIN - 1);
  localparam logic [PCW-1:0]   PC_NIN   = PCW'(NIN);
  localparam logic [PCW-1:0]   PC_LAST  = PCW'(NIN + 1);
  localparam logic [7:0]       N_LAST   = 8'(NOUT - 1);
  localparam logic [WABIT-1:0] W_STEP   = WABIT'(NIN);
  localparam logic signed [ACCBIT-1:0] OMAX =
    {{(ACCBIT-OBIT+1){1'b0}}, {(OBIT-1){1'b1}}};

  typedef enum logic {ST_LOAD, ST_COMPUTE} state_t;

  function automatic logic [OBIT-1:0] relu_sat(input logic signed [ACCBIT-1:0] s);
    if (s[ACCBIT-1])  return '0;
    else if (s > OMAX) return OMAX[OBIT-1:0];
    else               return s[OBIT-1:0];
  endfunction

  state_t                    state_q, state_d;
  logic        [CW-1:0]      cnt_q, cnt_d;
  logic        [PCW-1:0]     pc_q, pc_d;
  logic        [7:0]         n_q, n_d;
  logic        [WABIT-1:0]   base_q, base_d;
  logic signed [ACCBIT-1:0]  acc_q, acc_d;
  logic        [OBIT-1:0]    vec_q, vec_d;
  logic        [7:0]         idx_q, idx_d;
  logic                      dv_q, dv_d;
  logic                      done_q, done_d;
  logic                      ovr_q, ovr_d;

  logic signed [IBIT-1:0]    smp_q [NIN];
  logic                      wr_en;
  logic        [CW-1:0]      kidx;
  logic signed [PW-1:0]      prod;
  logic signed [ACCBIT-1:0]  bsum;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    n_d     = n_q;
    base_d  = base_q;
    acc_d   = acc_q;
    vec_d   = vec_q;
    idx_d   = idx_q;
    dv_d    = 1'b0;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    wr_en   = 1'b0;
    kidx    = '0;
    prod    = '0;
    bsum    = '0;
    case (state_q)
      ST_LOAD: begin
        if (dv_i) begin
          wr_en = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_COMPUTE;
            pc_d    = '0;
            n_d     = '0;
            base_d  = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        if (dv_i) ovr_d = 1'b1;
        pc_d = pc_q + PCW'(1);
        if (pc_q == '0) begin
          acc_d = '0;
        end else if (pc_q <= PC_NIN) begin
          // ROM data lags its address by one cycle, so pair it with sample pc-1
          kidx  = CW'(pc_q - PCW'(1));
          prod  = smp_q[kidx] * w_data;
          acc_d = acc_q + {{(ACCBIT-PW){prod[PW-1]}}, prod};
        end else begin
          bsum   = acc_q + {{(ACCBIT-BBIT){b_data[BBIT-1]}}, b_data};
          vec_d  = relu_sat(bsum >>> FRAC);
          idx_d  = n_q;
          dv_d   = 1'b1;
          pc_d   = '0;
          if (n_q == N_LAST) begin
            done_d  = 1'b1;
            state_d = ST_LOAD;
            n_d     = '0;
            base_d  = '0;
          end else begin
            n_d    = n_q + 8'd1;
            base_d = base_q + W_STEP;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      pc_q    <= '0;
      n_q     <= '0;
      base_q  <= '0;
      acc_q   <= '0;
      vec_q   <= '0;
      idx_q   <= '0;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      n_q     <= n_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
      dv_q    <= dv_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  // Sample window storage carries no reset; it is always fully rewritten before use
  always_ff @(posedge clk) begin
    if (wr_en) smp_q[cnt_q] <= vec_i;
  end

  assign w_addr  = (pc_q < PC_NIN) ? base_q + WABIT'(pc_q) : base_q;
  assign b_addr  = n_q;
  assign busy_o  = (state_q == ST_COMPUTE);
  assign dv_o    = dv_q;
  assign vec_o   = vec_q;
  assign index_o = idx_q;
  assign done_o  = done_q;
  assign ovr_o   = ovr_q;

endmodule

// File: tb/tb_dnn_l1_mac.sv
// Directed bench for dnn_l1_mac with behavioural synchronous weight/bias ROMs.
module tb_dnn_l1_mac;

  localparam int NIN  = 60;
  localparam int NOUT = 32;
  localparam int P    = NIN + 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               dv_i = 1'b0;
  logic signed [12:0] vec_i = '0;
  logic        [11:0] w_addr;
  logic signed [12:0] w_data = '0;
  logic        [7:0]  b_addr;
  logic signed [15:0] b_data = '0;
  logic               dv_o;
  logic signed [12:0] vec_o;
  logic        [7:0]  index_o;
  logic               busy_o, done_o, ovr_o;

  logic signed [12:0] w_rom [NIN*NOUT];
  logic signed [15:0] b_rom [NOUT];
  int                 exp_v [NOUT];
  int                 cyc = 0;
  int                 s_cyc = 0;
  int                 n_tests = 0;
  int                 n_fail = 0;

  dnn_l1_mac dut (
    .clk(clk), .rst(rst), .dv_i(dv_i), .vec_i(vec_i),
    .w_addr(w_addr), .w_data(w_data), .b_addr(b_addr), .b_data(b_data),
    .dv_o(dv_o), .vec_o(vec_o), .index_o(index_o),
    .busy_o(busy_o), .done_o(done_o), .ovr_o(ovr_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    w_data <= (int'(w_addr) < NIN*NOUT) ? w_rom[w_addr] : '0;
    b_data <= (int'(b_addr) < NOUT) ? b_rom[b_addr] : '0;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_rom(input int wv, input bit n0_only, input int b1, input int b2);
    for (int i = 0; i < NIN*NOUT; i++)
      w_rom[i] = (!n0_only || i < NIN) ? 13'(wv) : '0;
    for (int i = 0; i < NOUT; i++) b_rom[i] = '0;
    b_rom[1] = 16'(b1);
    b_rom[2] = 16'(b2);
  endtask

  task automatic fill_exp(input int v);
    for (int i = 0; i < NOUT; i++) exp_v[i] = v;
  endtask

  // now=1 drives the first beat in the current cycle (used for the done_o cycle)
  task automatic load_window(input int x, input bit gap, input bit now);
    for (int i = 0; i < NIN; i++) begin
      if (gap && i > 0) begin
        @(negedge clk);
        dv_i = 1'b0;
      end
      if (!(now && i == 0)) @(negedge clk);
      dv_i  = 1'b1;
      vec_i = 13'(x);
      s_cyc = cyc + 1;
    end
    @(negedge clk);
    dv_i = 1'b0;
    check("busy_at_S", longint'(busy_o), 1);
  endtask

  task automatic collect(input string tag);
    for (int n = 0; n < NOUT; n++) begin
      int t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!dv_o && t < 2*P);
      if (!dv_o) begin
        check({tag, "_timeout"}, 0, 1);
        return;
      end
      check({tag, "_vec"}, longint'(vec_o), exp_v[n]);
      check({tag, "_idx"}, longint'(index_o), n);
      check({tag, "_time"}, cyc, s_cyc + (n + 1) * P);
      check({tag, "_done"}, longint'(done_o), (n == NOUT-1) ? 1 : 0);
      check({tag, "_busy"}, longint'(busy_o), (n == NOUT-1) ? 0 : 1);
    end
  endtask

  initial begin
    int t;
    int seen;
    repeat (3) @(negedge clk);
    check("rst_dv", longint'(dv_o), 0);
    check("rst_vec", longint'(vec_o), 0);
    check("rst_idx", longint'(index_o), 0);
    check("rst_waddr", longint'(w_addr), 0);
    check("rst_baddr", longint'(b_addr), 0);
    check("rst_busy", longint'(busy_o), 0);
    check("rst_done", longint'(done_o), 0);
    check("rst_ovr", longint'(ovr_o), 0);
    rst = 1'b0;

    // 64*64*60 = 245760 -> >>12 = 60
    set_rom(64, 1'b0, 0, 0);
    fill_exp(60);
    load_window(64, 1'b0, 1'b0);
    collect("basic");

    set_rom(64, 1'b1, -4096, 4096);
    fill_exp(0);
    exp_v[0] = 60; exp_v[1] = 0; exp_v[2] = 1;
    load_window(64, 1'b0, 1'b0);
    collect("bias");

    set_rom(4095, 1'b0, 0, 0);
    fill_exp(4095);
    load_window(4095, 1'b0, 1'b0);
    collect("sat");

    set_rom(-4095, 1'b0, 0, 0);
    fill_exp(0);
    load_window(4095, 1'b0, 1'b0);
    collect("neg");
    check("ovr_clean", longint'(ovr_o), 0);

    set_rom(64, 1'b0, 0, 0);
    fill_exp(60);
    load_window(64, 1'b1, 1'b0);
    fork
      collect("gap");
      begin
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          dv_i  = 1'b1;
          vec_i = 13'sd1000;
        end
        @(negedge clk);
        dv_i = 1'b0;
      end
    join
    check("ovr_set", longint'(ovr_o), 1);
    repeat (5) @(negedge clk);
    check("ovr_sticky", longint'(ovr_o), 1);

    load_window(64, 1'b0, 1'b0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(dv_o && index_o == 8'd5) && t < 10*P);
    check("midrst_reach5", longint'(index_o), 5);
    #3 rst = 1'b1;
    #1;
    check("midrst_dv", longint'(dv_o), 0);
    check("midrst_vec", longint'(vec_o), 0);
    check("midrst_idx", longint'(index_o), 0);
    check("midrst_busy", longint'(busy_o), 0);
    check("midrst_waddr", longint'(w_addr), 0);
    check("midrst_ovr", longint'(ovr_o), 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (3*P) begin
      @(negedge clk);
      if (dv_o) seen++;
    end
    check("midrst_quiet", seen, 0);
    load_window(64, 1'b0, 1'b0);
    collect("reload");

    load_window(64, 1'b0, 1'b0);
    collect("b2b_a");
    // 128*64*60 = 491520 -> >>12 = 120
    fill_exp(120);
    load_window(128, 1'b0, 1'b1);
    collect("b2b_b");
    check("b2b_ovr", longint'(ovr_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
